// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store front-end.
// Op encodings match the execute-stage memory op field.
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } mem_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } mas_state_t;

    function automatic logic is_load(input mem_op_t op);
        return op <= OP_LBU;
    endfunction

    function automatic logic [2:0] op_size(input mem_op_t op);
        logic [2:0] sz;
        sz = 3'd4;
        unique case (op)
            OP_LH, OP_LHU, OP_SH: sz = 3'd2;
            OP_LB, OP_LBU, OP_SB: sz = 3'd1;
            default:              sz = 3'd4;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
// Purely combinational; little-endian lanes.
module lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  offset,
    input  mem_op_t     op,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half   = offset[1] ? rd_word[31:16] : rd_word[15:0];
    assign byte_v = rd_word[8*offset +: 8];

    always_comb begin
        load_data = rd_word;
        unique case (op)
            OP_LH:   load_data = {{16{half[15]}}, half};
            OP_LHU:  load_data = {16'd0, half};
            OP_LB:   load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_data = {24'd0, byte_v};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        merge_data = new_data;
        unique case (op)
            OP_SH: begin
                merge_data = old_word;
                merge_data[16*offset[1] +: 16] = new_data[15:0];
            end
            OP_SB: begin
                merge_data = old_word;
                merge_data[8*offset +: 8] = new_data[7:0];
            end
            default: merge_data = new_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: one request at a time, sub-word stores done
// as read-modify-write on a word-wide memory port.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam int AW = $clog2(MEM_WORDS);

    mas_state_t    state_q, state_d;
    mem_op_t       op_q, op_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   merge_q, merge_d;

    logic [31:0]   load_data;
    logic [31:0]   merge_data;
    logic          bad_req;
    mem_op_t       req_op_e;

    assign req_op_e = mem_op_t'(req_op);

    always_comb begin
        bad_req = (req_addr >> (AW + 2)) != 32'd0;
        if (op_size(req_op_e) == 3'd2 && req_addr[0])
            bad_req = 1'b1;
        if (op_size(req_op_e) == 3'd4 && req_addr[1:0] != 2'b00)
            bad_req = 1'b1;
    end

    lane_align u_lane_align (
        .rd_word    (mem_rd),
        .old_word   (merge_q),
        .new_data   (wdata_q),
        .offset     (addr_q[1:0]),
        .op         (op_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Port strobes are gated by rst so a reset cycle never writes memory.
    assign req_ready  = !rst && state_q == S_IDLE;
    assign mem_re     = !rst && (state_q == S_LOAD || state_q == S_RMW_RD);
    assign mem_we     = !rst && (state_q == S_STORE || state_q == S_RMW_WR);
    assign resp_valid = !rst && state_q == S_RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        mem_addr = 32'd0;
        if (mem_re || mem_we)
            mem_addr = {{(32 - AW){1'b0}}, addr_q[AW+1:2]};
    end

    always_comb begin
        mem_wd = 32'd0;
        if (mem_we)
            mem_wd = (state_q == S_STORE) ? wdata_q : merge_data;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        merge_d = merge_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op_e;
                    addr_d  = req_addr[AW+1:0];
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = bad_req;
                    if (bad_req)
                        state_d = S_RESP;
                    else if (is_load(req_op_e))
                        state_d = S_LOAD;
                    else if (req_op_e == OP_SW)
                        state_d = S_STORE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = load_data;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = mem_rd;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_RESP;
            S_STORE:  state_d = S_RESP;
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            merge_q <= merge_d;
        end
    end

endmodule
